// File: rtl/alu.sv
// alu: registered 16-op integer ALU (add/sub, logic, shifts/rotate, inc/dec, slt, pass).
// Latency: one clk from A/B/OP to RESULT and flags; a new operation is taken every cycle.
// Backpressure: none; there is no handshake and the result is overwritten every cycle.
//
// Ports:
//   clk       rising-edge clock, all outputs registered on it
//   rst       asynchronous active-high reset (RESULT=0, CARRY=0, OVERFLOW=0, ZERO=1)
//   A, B      operands (WIDTH bits); shifts and rotates use B[3:0] as the amount
//   OP        4-bit operation select
//   RESULT    registered result
//   CARRY     registered carry / borrow / last shifted-out bit
//   OVERFLOW  registered signed-overflow flag
//   ZERO      registered flag, set when the result being registered is zero
module alu #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       OP,
   output logic [WIDTH-1:0] RESULT,
   output logic             CARRY,
   output logic             OVERFLOW,
   output logic             ZERO
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_AND  = 4'h2,
      OP_OR   = 4'h3,
      OP_XOR  = 4'h4,
      OP_NOT  = 4'h5,
      OP_NAND = 4'h6,
      OP_NOR  = 4'h7,
      OP_SHL  = 4'h8,
      OP_SHR  = 4'h9,
      OP_SAR  = 4'hA,
      OP_ROL  = 4'hB,
      OP_INC  = 4'hC,
      OP_DEC  = 4'hD,
      OP_SLT  = 4'hE,
      OP_PASS = 4'hF
   } op_e;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   op_e             op_sel;
   logic [3:0]      shamt;
   logic            is_sub;
   logic [WIDTH-1:0] arith_b;
   logic [WIDTH:0]  sum;
   logic            arith_ovf;
   logic [WIDTH:0]  shl_ext;
   logic [WIDTH:0]  shr_ext;
   logic [WIDTH:0]  sar_ext;
   logic [WIDTH-1:0] rol_res;
   logic [31:0]     rol_back;
   logic            slt;

   logic [WIDTH-1:0] res_nxt;
   logic            carry_nxt;
   logic            ovf_nxt;

   assign op_sel = op_e'(OP);
   assign shamt  = B[3:0];

   // ADD/SUB/INC/DEC share one WIDTH+1 bit adder; bit WIDTH is carry for add
   // and borrow for subtract.
   assign is_sub  = (op_sel == OP_SUB) || (op_sel == OP_DEC);
   assign arith_b = ((op_sel == OP_INC) || (op_sel == OP_DEC)) ? ONE : B;
   assign sum     = is_sub ? ({1'b0, A} - {1'b0, arith_b})
                           : ({1'b0, A} + {1'b0, arith_b});
   // Add overflows when operand signs match, subtract when they differ; in both
   // cases the result sign then disagrees with A.
   assign arith_ovf = ((A[WIDTH-1] ^ arith_b[WIDTH-1]) == is_sub) &&
                      (sum[WIDTH-1] != A[WIDTH-1]);

   // Shifts run one bit wider so the last bit pushed out lands in the extra
   // bit; with a zero amount that extra bit is the padding zero.
   assign shl_ext  = {1'b0, A} << shamt;
   assign shr_ext  = {A, 1'b0} >> shamt;
   assign sar_ext  = $signed({A, 1'b0}) >>> shamt;
   assign rol_back = 32'(WIDTH) - 32'(shamt);
   assign rol_res  = (A << shamt) | (A >> rol_back);

   assign slt = $signed(A) < $signed(B);

   always_comb begin
      res_nxt   = '0;
      carry_nxt = 1'b0;
      ovf_nxt   = 1'b0;
      case (op_sel)
         OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
            res_nxt   = sum[WIDTH-1:0];
            carry_nxt = sum[WIDTH];
            ovf_nxt   = arith_ovf;
         end
         OP_AND:  res_nxt = A & B;
         OP_OR:   res_nxt = A | B;
         OP_XOR:  res_nxt = A ^ B;
         OP_NOT:  res_nxt = ~A;
         OP_NAND: res_nxt = ~(A & B);
         OP_NOR:  res_nxt = ~(A | B);
         OP_SHL: begin
            res_nxt   = shl_ext[WIDTH-1:0];
            carry_nxt = shl_ext[WIDTH];
         end
         OP_SHR: begin
            res_nxt   = shr_ext[WIDTH:1];
            carry_nxt = shr_ext[0];
         end
         OP_SAR: begin
            res_nxt   = sar_ext[WIDTH:1];
            carry_nxt = sar_ext[0];
         end
         OP_ROL:  res_nxt = rol_res;
         OP_SLT:  res_nxt = {{(WIDTH-1){1'b0}}, slt};
         OP_PASS: res_nxt = A;
         default: res_nxt = '0;
      endcase
   end

   // ZERO comes from the value being registered, not the old RESULT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RESULT   <= '0;
         CARRY    <= 1'b0;
         OVERFLOW <= 1'b0;
         ZERO     <= 1'b1;
      end else begin
         RESULT   <= res_nxt;
         CARRY    <= carry_nxt;
         OVERFLOW <= ovf_nxt;
         ZERO     <= (res_nxt == '0);
      end
   end

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu (WIDTH=16).
// Latency: expects results one clk after the operands are applied.
// Backpressure: none; operands are changed every cycle.
module tb_alu;

   logic        clk;
   logic        rst;
   logic [15:0] A;
   logic [15:0] B;
   logic [3:0]  OP;
   logic [15:0] RESULT;
   logic        CARRY;
   logic        OVERFLOW;
   logic        ZERO;

   int errors = 0;
   int checks = 0;

   alu #(.WIDTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .A        (A),
      .B        (B),
      .OP       (OP),
      .RESULT   (RESULT),
      .CARRY    (CARRY),
      .OVERFLOW (OVERFLOW),
      .ZERO     (ZERO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
      logic        c;
      logic        v;
      logic        z;
   } vec_t;

   // Reference model: plain integer arithmetic and bit-at-a-time shifting.
   function automatic void model(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, output logic [15:0] r,
                                 output logic c, output logic v, output logic z);
      int sa, sb, ua, ub, n;
      sa = int'($signed(a));
      sb = int'($signed(b));
      ua = int'(a);
      ub = int'(b);
      n  = int'(b[3:0]);
      r = 16'h0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'h0: begin
            r = 16'(ua + ub);
            c = (ua + ub) > 65535;
            v = (sa + sb) > 32767 || (sa + sb) < -32768;
         end
         4'h1: begin
            r = 16'(ua - ub);
            c = ua < ub;
            v = (sa - sb) > 32767 || (sa - sb) < -32768;
         end
         4'h2: r = a & b;
         4'h3: r = a | b;
         4'h4: r = a ^ b;
         4'h5: r = ~a;
         4'h6: r = ~(a & b);
         4'h7: r = ~(a | b);
         4'h8: begin
            r = a;
            for (int i = 0; i < n; i++) begin c = r[15]; r = {r[14:0], 1'b0}; end
         end
         4'h9: begin
            r = a;
            for (int i = 0; i < n; i++) begin c = r[0]; r = {1'b0, r[15:1]}; end
         end
         4'hA: begin
            r = a;
            for (int i = 0; i < n; i++) begin c = r[0]; r = {r[15], r[15:1]}; end
         end
         4'hB: begin
            r = a;
            for (int i = 0; i < n; i++) r = {r[14:0], r[15]};
         end
         4'hC: begin
            r = 16'(ua + 1);
            c = (ua + 1) > 65535;
            v = (sa + 1) > 32767;
         end
         4'hD: begin
            r = 16'(ua - 1);
            c = (ua == 0);
            v = (sa - 1) < -32768;
         end
         4'hE: r = (sa < sb) ? 16'd1 : 16'd0;
         default: r = a;
      endcase
      z = (r == 16'h0);
   endfunction

   // Apply operands, then sample 1 time unit after the capturing edge.
   task automatic step(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      OP = op;
      A  = a;
      B  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if ({RESULT, CARRY, OVERFLOW, ZERO} !== {16'h0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_initial: got r=%h c=%b v=%b z=%b want r=0000 c=0 v=0 z=1",
                  RESULT, CARRY, OVERFLOW, ZERO);
      end
      step(4'h0, 16'd10, 16'd5);
      checks++;
      if ({RESULT, CARRY, OVERFLOW, ZERO} !== {16'h0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_held_over_edge: got r=%h c=%b v=%b z=%b want r=0000 c=0 v=0 z=1",
                  RESULT, CARRY, OVERFLOW, ZERO);
      end
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({RESULT, CARRY, OVERFLOW, ZERO} !== {16'd15, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL first_edge_after_reset: got r=%h c=%b v=%b z=%b want r=000f c=0 v=0 z=0",
                  RESULT, CARRY, OVERFLOW, ZERO);
      end
   endtask

   task automatic test_directed;
      vec_t t [25];
      t = '{
         '{4'h0, 16'd10,    16'd5,    16'd15,   1'b0, 1'b0, 1'b0},
         '{4'h0, 16'h7FFF,  16'd1,    16'h8000, 1'b0, 1'b1, 1'b0},
         '{4'h1, 16'd10,    16'd5,    16'd5,    1'b0, 1'b0, 1'b0},
         '{4'h1, 16'h8000,  16'd1,    16'h7FFF, 1'b0, 1'b1, 1'b0},
         '{4'h0, 16'd0,     16'd0,    16'd0,    1'b0, 1'b0, 1'b1},
         '{4'h0, 16'hFFFF,  16'd1,    16'd0,    1'b1, 1'b0, 1'b1},
         '{4'h1, 16'd3,     16'd5,    16'hFFFE, 1'b1, 1'b0, 1'b0},
         '{4'hC, 16'hFFFF,  16'h1234, 16'd0,    1'b1, 1'b0, 1'b1},
         '{4'hC, 16'h7FFF,  16'h0,    16'h8000, 1'b0, 1'b1, 1'b0},
         '{4'hD, 16'h0,     16'h0,    16'hFFFF, 1'b1, 1'b0, 1'b0},
         '{4'hD, 16'h8000,  16'h0,    16'h7FFF, 1'b0, 1'b1, 1'b0},
         '{4'h8, 16'h8001,  16'd1,    16'h0002, 1'b1, 1'b0, 1'b0},
         '{4'h8, 16'hFFFF,  16'd0,    16'hFFFF, 1'b0, 1'b0, 1'b0},
         '{4'h8, 16'h0003,  16'd15,   16'h8000, 1'b1, 1'b0, 1'b0},
         '{4'h9, 16'h0001,  16'd1,    16'h0000, 1'b1, 1'b0, 1'b1},
         '{4'h9, 16'h8000,  16'h00F4, 16'h0800, 1'b0, 1'b0, 1'b0},
         '{4'hA, 16'h8000,  16'd15,   16'hFFFF, 1'b0, 1'b0, 1'b0},
         '{4'hA, 16'h8001,  16'd1,    16'hC000, 1'b1, 1'b0, 1'b0},
         '{4'hA, 16'h8001,  16'd0,    16'h8001, 1'b0, 1'b0, 1'b0},
         '{4'hB, 16'h8001,  16'd4,    16'h0018, 1'b0, 1'b0, 1'b0},
         '{4'hE, 16'hFFFF,  16'd1,    16'd1,    1'b0, 1'b0, 1'b0},
         '{4'hE, 16'd1,     16'hFFFF, 16'd0,    1'b0, 1'b0, 1'b1},
         '{4'h5, 16'hFFFF,  16'h0,    16'd0,    1'b0, 1'b0, 1'b1},
         '{4'h7, 16'h00F0,  16'h0F00, 16'hF00F, 1'b0, 1'b0, 1'b0},
         '{4'hF, 16'hA5A5,  16'h0,    16'hA5A5, 1'b0, 1'b0, 1'b0}
      };
      foreach (t[i]) begin
         step(t[i].op, t[i].a, t[i].b);
         checks++;
         if ({RESULT, CARRY, OVERFLOW, ZERO} !== {t[i].r, t[i].c, t[i].v, t[i].z}) begin
            errors++;
            $display("FAIL directed[%0d] op=%h a=%h b=%h: got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
                     i, t[i].op, t[i].a, t[i].b, RESULT, CARRY, OVERFLOW, ZERO,
                     t[i].r, t[i].c, t[i].v, t[i].z);
         end
      end
   endtask

   task automatic test_random;
      logic [15:0] corner [4];
      logic [3:0]  op;
      logic [15:0] a, b, er;
      logic        ec, ev, ez;
      corner = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
      for (int i = 0; i < 600; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
         model(op, a, b, er, ec, ev, ez);
         step(op, a, b);
         checks++;
         if ({RESULT, CARRY, OVERFLOW, ZERO} !== {er, ec, ev, ez}) begin
            errors++;
            $display("FAIL random[%0d] op=%h a=%h b=%h: got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
                     i, op, a, b, RESULT, CARRY, OVERFLOW, ZERO, er, ec, ev, ez);
         end
      end
   endtask

   // ZERO must follow each cycle's own result through nonzero/zero transitions.
   task automatic test_back_to_back;
      vec_t t [6];
      logic [15:0] er;
      logic        ec, ev, ez;
      t = '{
         '{4'h0, 16'd1,    16'd1,    16'h0, 1'b0, 1'b0, 1'b0},
         '{4'h1, 16'd5,    16'd5,    16'h0, 1'b0, 1'b0, 1'b0},
         '{4'h4, 16'h1234, 16'h1234, 16'h0, 1'b0, 1'b0, 1'b0},
         '{4'hF, 16'd7,    16'd0,    16'h0, 1'b0, 1'b0, 1'b0},
         '{4'h2, 16'h00FF, 16'hFF00, 16'h0, 1'b0, 1'b0, 1'b0},
         '{4'h0, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0, 1'b0, 1'b0}
      };
      foreach (t[i]) begin
         model(t[i].op, t[i].a, t[i].b, er, ec, ev, ez);
         step(t[i].op, t[i].a, t[i].b);
         checks++;
         if ({RESULT, CARRY, OVERFLOW, ZERO} !== {er, ec, ev, ez}) begin
            errors++;
            $display("FAIL back_to_back[%0d]: got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
                     i, RESULT, CARRY, OVERFLOW, ZERO, er, ec, ev, ez);
         end
      end
   endtask

   task automatic test_async_reset;
      step(4'h0, 16'h7FFF, 16'd1);
      checks++;
      if ({RESULT, CARRY, OVERFLOW, ZERO} !== {16'h8000, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL async_pre: got r=%h c=%b v=%b z=%b want r=8000 c=0 v=1 z=0",
                  RESULT, CARRY, OVERFLOW, ZERO);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({RESULT, CARRY, OVERFLOW, ZERO} !== {16'h0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL async_assert_no_edge: got r=%h c=%b v=%b z=%b want r=0000 c=0 v=0 z=1",
                  RESULT, CARRY, OVERFLOW, ZERO);
      end
      step(4'h0, 16'hFFFF, 16'd1);
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({RESULT, CARRY, OVERFLOW, ZERO} !== {16'h0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL async_release_no_edge: got r=%h c=%b v=%b z=%b want r=0000 c=0 v=0 z=1",
                  RESULT, CARRY, OVERFLOW, ZERO);
      end
      step(4'h1, 16'd3, 16'd5);
      checks++;
      if ({RESULT, CARRY, OVERFLOW, ZERO} !== {16'hFFFE, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL async_first_op: got r=%h c=%b v=%b z=%b want r=fffe c=1 v=0 z=0",
                  RESULT, CARRY, OVERFLOW, ZERO);
      end
   endtask

   initial begin
      rst = 1'b1;
      A   = 16'h0;
      B   = 16'h0;
      OP  = 4'h0;
      test_reset;
      test_directed;
      test_back_to_back;
      test_random;
      test_async_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width; all values below assume 16.
REQ-002 clk  input  1  rising-edge clock; all outputs registered on it.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 A  input  16  operand A, two's-complement signed or unsigned depending on the op.
REQ-005 B  input  16  operand B.
REQ-006 OP  input  4  operation select.
REQ-007 RESULT  output  16  registered operation result.
REQ-008 CARRY  output  1  registered carry/borrow/shift-out flag.
REQ-009 OVERFLOW  output  1  registered signed-overflow flag.
REQ-010 ZERO  output  1  registered flag, 1 when RESULT == 0.

Function
REQ-011 The datapath shall be combinational from A/B/OP; RESULT and all flags shall be captured on each rising clk edge, giving a 1-cycle latency with a new operation accepted every cycle (no handshake).
REQ-012 The opcode map shall be:
- 0000 ADD: A+B.
- 0001 SUB: A-B.
- 0010 AND.
- 0011 OR.
- 0100 XOR.
- 0101 NOT A.
- 0110 NAND.
- 0111 NOR.
- 1000 SHL A by B[3:0].
- 1001 SHR logical A by B[3:0].
- 1010 SAR arithmetic A by B[3:0].
- 1011 ROL A by B[3:0].
- 1100 INC A+1.
- 1101 DEC A-1.
- 1110 SLT: signed A<B → 1, else 0.
- 1111 PASS A.
REQ-013 ADD/INC shall set CARRY to bit 16 of the unsigned 17-bit sum.
REQ-014 ADD/INC shall set OVERFLOW=1 when both operands have the same sign and the result sign differs.
REQ-015 SUB/DEC shall set CARRY=1 on unsigned borrow (A<B, or A==0 for DEC).
REQ-016 SUB/DEC shall set OVERFLOW=1 when the operand signs differ and the result sign differs from A.
REQ-017 SHL shall set CARRY to the last bit shifted out of bit 15; SHR and SAR shall set CARRY to the last bit shifted out of bit 0; a shift amount of 0 shall give CARRY=0.
REQ-018 SHL, SHR, SAR, ROL, logic ops, SLT and PASS shall set OVERFLOW=0.
REQ-019 Logic ops, ROL, SLT and PASS shall set CARRY=0.
REQ-020 ZERO shall be derived from the same-cycle result value, not from the previous registered RESULT.
REQ-021 Wrap-around: arithmetic results shall be truncated modulo 2^16 and never saturate.
REQ-022 Overflow detection shall be sign-based, independent of CARRY.

Reset
REQ-023 While rst=1 (asserted asynchronously, at any time including mid-operation), outputs shall be RESULT=0, CARRY=0, OVERFLOW=0, ZERO=1.
REQ-024 Once rst is released, the first rising clk edge shall register the current operation normally.

Verification
REQ-025 ADD, A=10, B=5, one edge → RESULT=15, CARRY=0, OVERFLOW=0, ZERO=0.
REQ-026 ADD, A=32767, B=1 → RESULT=-32768 (0x8000), CARRY=0, OVERFLOW=1, ZERO=0.
REQ-027 SUB, A=10, B=5 → RESULT=5, CARRY=0, OVERFLOW=0, ZERO=0.
REQ-028 SUB, A=-32768, B=1 → RESULT=32767 (0x7FFF), CARRY=0, OVERFLOW=1, ZERO=0.
REQ-029 ADD, A=0, B=0 → RESULT=0, ZERO=1.
REQ-030 ADD, A=0xFFFF, B=1 → RESULT=0, CARRY=1, OVERFLOW=0, ZERO=1.
REQ-031 Assert rst between clock edges after any of the above → outputs return to reset values immediately, without waiting for a clock edge.
